// File: rtl/morse_tx.sv
`default_nettype none
// ============================================================================
//  Module   : morse_tx
//  Brief    : A-Z Morse code transmitter. Latches a letter index on start and
//             serialises its dot/dash pattern LSB first on morse_out, one
//             pattern bit per TICK_CYCLES clocks. Reports busy/done and
//             supports abort.
//             Optional auto-repeat with a three-unit gap between letters,
//             enabled by defining MORSE_TX_REPEAT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module morse_tx #(
    parameter int TICK_CYCLES = 25_000_000,
    parameter int PAT_W       = 13
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [4:0] letter_sel,
    input  logic       start,
    input  logic       abort,
    // 'repeat' is a reserved word, so the auto-repeat request is repeat_req
    input  logic       repeat_req,
    output logic       morse_out,
    output logic       busy,
    output logic       done
);

    localparam int c_CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_TICK_LAST = c_CNT_W'(TICK_CYCLES - 1);
    localparam logic [3:0] c_GAP_UNITS = 4'd3;
    localparam logic [4:0] c_NUM_LETTERS = 5'd26;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PAT_W-1:0]   r_shift;
    logic [PAT_W-1:0]   w_shift_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [3:0]         r_bits;
    logic [3:0]         w_bits_nxt;
    logic               r_morse;
    logic               w_morse_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_done;
    logic               w_done_nxt;

    logic [12:0]        w_rom_pat13;
    logic [PAT_W-1:0]   w_rom_pat;
    logic [3:0]         w_rom_len;
    logic               w_sel_ok;
    logic               w_unit_end;

    assign w_sel_ok   = (letter_sel < c_NUM_LETTERS);
    assign w_unit_end = (r_cnt == c_TICK_LAST);

    // Letter ROM: pattern literals are MSB-left, so the first element sits in
    // the rightmost bits and is emitted first.
    always_comb begin
        w_rom_pat13 = 13'd0;
        w_rom_len   = 4'd0;
        case (letter_sel)
            5'd0:  begin w_rom_pat13 = 13'b0000000011101; w_rom_len = 4'd5;  end // A .-
            5'd1:  begin w_rom_pat13 = 13'b0000101010111; w_rom_len = 4'd9;  end // B -...
            5'd2:  begin w_rom_pat13 = 13'b0010111010111; w_rom_len = 4'd11; end // C -.-.
            5'd3:  begin w_rom_pat13 = 13'b0000001010111; w_rom_len = 4'd7;  end // D -..
            5'd4:  begin w_rom_pat13 = 13'b0000000000001; w_rom_len = 4'd1;  end // E .
            5'd5:  begin w_rom_pat13 = 13'b0000101110101; w_rom_len = 4'd9;  end // F ..-.
            5'd6:  begin w_rom_pat13 = 13'b0000101110111; w_rom_len = 4'd9;  end // G --.
            5'd7:  begin w_rom_pat13 = 13'b0000001010101; w_rom_len = 4'd7;  end // H ....
            5'd8:  begin w_rom_pat13 = 13'b0000000000101; w_rom_len = 4'd3;  end // I ..
            5'd9:  begin w_rom_pat13 = 13'b1110111011101; w_rom_len = 4'd13; end // J .---
            5'd10: begin w_rom_pat13 = 13'b0000111010111; w_rom_len = 4'd9;  end // K -.-
            5'd11: begin w_rom_pat13 = 13'b0000101011101; w_rom_len = 4'd9;  end // L .-..
            5'd12: begin w_rom_pat13 = 13'b0000001110111; w_rom_len = 4'd7;  end // M --
            5'd13: begin w_rom_pat13 = 13'b0000000010111; w_rom_len = 4'd5;  end // N -.
            5'd14: begin w_rom_pat13 = 13'b0011101110111; w_rom_len = 4'd11; end // O ---
            5'd15: begin w_rom_pat13 = 13'b0010111011101; w_rom_len = 4'd11; end // P .--.
            5'd16: begin w_rom_pat13 = 13'b1110101110111; w_rom_len = 4'd13; end // Q --.-
            5'd17: begin w_rom_pat13 = 13'b0000001011101; w_rom_len = 4'd7;  end // R .-.
            5'd18: begin w_rom_pat13 = 13'b0000000010101; w_rom_len = 4'd5;  end // S ...
            5'd19: begin w_rom_pat13 = 13'b0000000000111; w_rom_len = 4'd3;  end // T -
            5'd20: begin w_rom_pat13 = 13'b0000001110101; w_rom_len = 4'd7;  end // U ..-
            5'd21: begin w_rom_pat13 = 13'b0000111010101; w_rom_len = 4'd9;  end // V ...-
            5'd22: begin w_rom_pat13 = 13'b0000111011101; w_rom_len = 4'd9;  end // W .--
            5'd23: begin w_rom_pat13 = 13'b0011101010111; w_rom_len = 4'd11; end // X -..-
            5'd24: begin w_rom_pat13 = 13'b1110111010111; w_rom_len = 4'd13; end // Y -.--
            5'd25: begin w_rom_pat13 = 13'b0010101110111; w_rom_len = 4'd11; end // Z --..
            default: begin w_rom_pat13 = 13'd0; w_rom_len = 4'd0; end
        endcase
    end

    // Widen the 13-bit ROM word to the configured shift register width
    generate
        if (PAT_W > 13) begin : g_pat_wide
            assign w_rom_pat = {{(PAT_W-13){1'b0}}, w_rom_pat13};
        end else begin : g_pat_exact
            assign w_rom_pat = w_rom_pat13;
        end
    endgenerate

`ifndef MORSE_TX_REPEAT_EN
    // Auto-repeat is not built; keep the port tied off for lint
    logic w_unused;
    assign w_unused = repeat_req;
`endif

    // Next-state and registered-output logic; abort overrides every state
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_bits_nxt  = r_bits;
        w_morse_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;

        if (abort) begin
            w_state_nxt = S_IDLE;
            w_shift_nxt = '0;
            w_cnt_nxt   = '0;
            w_bits_nxt  = 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && w_sel_ok) begin
                        w_state_nxt = S_SEND;
                        w_shift_nxt = w_rom_pat;
                        w_bits_nxt  = w_rom_len;
                        w_cnt_nxt   = '0;
                        w_morse_nxt = w_rom_pat[0];
                        w_busy_nxt  = 1'b1;
                    end
                end

                S_SEND: begin
                    w_busy_nxt = 1'b1;
                    if (w_unit_end) begin
                        w_shift_nxt = r_shift >> 1;
                        w_cnt_nxt   = '0;
                        w_bits_nxt  = r_bits - 4'd1;
                        if (r_bits == 4'd1) begin
                            // Last unit of the letter has expired
                            w_done_nxt  = 1'b1;
                            w_morse_nxt = 1'b0;
                            w_state_nxt = S_IDLE;
                            w_busy_nxt  = 1'b0;
`ifdef MORSE_TX_REPEAT_EN
                            if (repeat_req) begin
                                w_state_nxt = S_GAP;
                                w_bits_nxt  = c_GAP_UNITS;
                                w_busy_nxt  = 1'b1;
                            end
`endif
                        end else begin
                            w_morse_nxt = r_shift[1];
                        end
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                        w_morse_nxt = r_shift[0];
                    end
                end

`ifdef MORSE_TX_REPEAT_EN
                S_GAP: begin
                    w_busy_nxt = 1'b1;
                    if (w_unit_end) begin
                        w_cnt_nxt = '0;
                        if (r_bits == 4'd1) begin
                            // Gap over: resample the letter and resend
                            if (w_sel_ok) begin
                                w_state_nxt = S_SEND;
                                w_shift_nxt = w_rom_pat;
                                w_bits_nxt  = w_rom_len;
                                w_morse_nxt = w_rom_pat[0];
                            end else begin
                                w_state_nxt = S_IDLE;
                                w_shift_nxt = '0;
                                w_bits_nxt  = 4'd0;
                                w_busy_nxt  = 1'b0;
                            end
                        end else begin
                            w_bits_nxt = r_bits - 4'd1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
`endif

                default: begin
                    w_state_nxt = S_IDLE;
                    w_shift_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_bits_nxt  = 4'd0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_bits  <= 4'd0;
            r_morse <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bits  <= w_bits_nxt;
            r_morse <= w_morse_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign morse_out = r_morse;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_morse_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_morse_tx
//  Brief    : Self-checking bench for morse_tx. Table of letters with their
//             hand-derived emission strings, plus directed sequences for
//             abort, reset, ignored starts, held start, the one-clock rate
//             and (with MORSE_TX_REPEAT_EN) auto-repeat.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_morse_tx;

    logic       CLOCK_50;
    logic       reset;
    logic [4:0] r_sel;
    logic       r_start4;
    logic       r_start1;
    logic       r_start2;
    logic       r_abort;
    logic       r_rpt;
    logic       w_m4, w_b4, w_d4;
    logic       w_m1, w_b1, w_d1;
    logic       w_m2, w_b2, w_d2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] sel;
        string      pat;
    } vec_t;

    vec_t tbl[6];

    morse_tx #(.TICK_CYCLES(4), .PAT_W(13)) u_dut4 (
        .CLOCK_50(CLOCK_50), .reset(reset), .letter_sel(r_sel), .start(r_start4),
        .abort(r_abort), .repeat_req(r_rpt), .morse_out(w_m4), .busy(w_b4), .done(w_d4)
    );

    morse_tx #(.TICK_CYCLES(1), .PAT_W(13)) u_dut1 (
        .CLOCK_50(CLOCK_50), .reset(reset), .letter_sel(r_sel), .start(r_start1),
        .abort(r_abort), .repeat_req(r_rpt), .morse_out(w_m1), .busy(w_b1), .done(w_d1)
    );

    morse_tx #(.TICK_CYCLES(2), .PAT_W(13)) u_dut2 (
        .CLOCK_50(CLOCK_50), .reset(reset), .letter_sel(r_sel), .start(r_start2),
        .abort(r_abort), .repeat_req(r_rpt), .morse_out(w_m2), .busy(w_b2), .done(w_d2)
    );

    // 50 MHz-style free-running clock
    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    function automatic logic [2:0] get_out(input int d);
        case (d)
            1:       get_out = {w_m1, w_b1, w_d1};
            2:       get_out = {w_m2, w_b2, w_d2};
            default: get_out = {w_m4, w_b4, w_d4};
        endcase
    endfunction

    task automatic set_start(input int d, input logic v);
        case (d)
            1:       r_start1 = v;
            2:       r_start2 = v;
            default: r_start4 = v;
        endcase
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Compare {morse_out, busy, done}
    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: {morse,busy,done} got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Start a letter on dut d and follow it cycle by cycle through done.
    // If poke >= 0, a start for E is pulsed at that cycle and must be ignored.
    task automatic send_check(input int d, input int tick, input logic [4:0] sel,
                              input string pat, input int poke);
        int len;
        logic bitv;
        len   = pat.len();
        r_sel = sel;
        set_start(d, 1'b1);
        step();
        set_start(d, 1'b0);
        for (int n = 0; n < tick * len; n++) begin
            if (n > 0) step();
            bitv = (pat[n / tick] == "1");
            chk("send_bit", get_out(d), {bitv, 1'b1, 1'b0});
            if (n == poke) begin
                set_start(d, 1'b1);
                r_sel = 5'd4;
            end else begin
                set_start(d, 1'b0);
            end
        end
        set_start(d, 1'b0);
        step();
        chk("send_done", get_out(d), 3'b001);
        for (int n = 0; n < 3; n++) begin
            step();
            chk("send_after", get_out(d), 3'b000);
        end
    endtask

    logic [2:0] rexp [28];
    logic       found;

    initial begin
        tbl[0] = '{sel: 5'd18, pat: "10101"};         // S ...
        tbl[1] = '{sel: 5'd4,  pat: "1"};             // E .
        tbl[2] = '{sel: 5'd25, pat: "11101110101"};   // Z --..
        tbl[3] = '{sel: 5'd19, pat: "111"};           // T -
        tbl[4] = '{sel: 5'd0,  pat: "10111"};         // A .-
        tbl[5] = '{sel: 5'd9,  pat: "1011101110111"}; // J .---

        reset    = 1'b0;
        r_sel    = 5'd0;
        r_start4 = 1'b0;
        r_start1 = 1'b0;
        r_start2 = 1'b0;
        r_abort  = 1'b0;
        r_rpt    = 1'b0;

        #12;
        chk("reset_dut4", get_out(4), 3'b000);
        chk("reset_dut1", get_out(1), 3'b000);
        chk("reset_dut2", get_out(2), 3'b000);
        reset = 1'b1;
        step();
        step();

        // Table-driven letters at four clocks per unit
        for (int i = 0; i < 6; i++) begin
            send_check(4, 4, tbl[i].sel, tbl[i].pat, -1);
        end

        // Invalid letter index: never accepted
        r_sel    = 5'd30;
        r_start4 = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("invalid_sel", get_out(4), 3'b000);
        end
        r_start4 = 1'b0;
        step();
        chk("invalid_sel_after", get_out(4), 3'b000);

        // Start pulse during T is ignored; done exactly once at +12
        send_check(4, 4, 5'd19, "111", 5);

        // Abort during S: start sampled at edge 0, abort sampled at edge 7
        r_sel    = 5'd18;
        r_start4 = 1'b1;
        step();
        r_start4 = 1'b0;
        for (int n = 0; n <= 6; n++) begin
            if (n > 0) step();
            chk("abort_pre", get_out(4), {(n < 4), 1'b1, 1'b0});
        end
        r_abort = 1'b1;
        step();
        chk("abort_out", get_out(4), 3'b000);
        r_abort = 1'b0;
        for (int n = 0; n < 24; n++) begin
            step();
            chk("abort_no_done", get_out(4), 3'b000);
        end

        // abort and start together in IDLE: abort wins
        r_sel    = 5'd4;
        r_start4 = 1'b1;
        r_abort  = 1'b1;
        step();
        chk("abort_vs_start", get_out(4), 3'b000);
        r_start4 = 1'b0;
        r_abort  = 1'b0;
        step();
        chk("abort_vs_start2", get_out(4), 3'b000);
        send_check(4, 4, 5'd4, "1", -1);

        // Asynchronous reset in the middle of Z
        r_sel    = 5'd25;
        r_start4 = 1'b1;
        step();
        r_start4 = 1'b0;
        for (int n = 0; n < 5; n++) step();
        chk("pre_reset_busy", get_out(4), 3'b110);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset", get_out(4), 3'b000);
        step();
        chk("reset_held", get_out(4), 3'b000);
        reset = 1'b1;
        step();
        send_check(4, 4, 5'd18, "10101", -1);

        // Held start: back-to-back retransmission with no gap
        r_sel    = 5'd19;
        r_start4 = 1'b1;
        for (int n = 0; n < 12; n++) begin
            step();
            chk("held_bit", get_out(4), 3'b110);
        end
        step();
        chk("held_done", get_out(4), 3'b001);
        step();
        chk("held_restart", get_out(4), 3'b110);
        r_start4 = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            step();
            if (w_d4) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL held_second_done: no done within 20 cycles, required one");
        end
        step();
        chk("held_idle", get_out(4), 3'b000);

        // One bit per clock: Y -.--
        send_check(1, 1, 5'd24, "1110101110111", -1);

`ifdef MORSE_TX_REPEAT_EN
        // Auto-repeat of T at two clocks per unit, switching to E in a gap
        for (int n = 0; n < 6; n++)   rexp[n] = 3'b110;
        rexp[6] = 3'b011;
        for (int n = 7; n < 12; n++)  rexp[n] = 3'b010;
        for (int n = 12; n < 18; n++) rexp[n] = 3'b110;
        rexp[18] = 3'b011;
        for (int n = 19; n < 24; n++) rexp[n] = 3'b010;
        rexp[24] = 3'b110;
        rexp[25] = 3'b110;
        rexp[26] = 3'b001;
        rexp[27] = 3'b000;
        r_sel    = 5'd19;
        r_rpt    = 1'b1;
        r_start2 = 1'b1;
        step();
        r_start2 = 1'b0;
        for (int n = 0; n < 28; n++) begin
            if (n > 0) step();
            chk("repeat_seq", get_out(2), rexp[n]);
            if (n == 19) r_sel = 5'd4;
            if (n == 25) r_rpt = 1'b0;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/morse_tx.md
# morse_tx

Parametrised Morse code transmitter covering the full A–Z alphabet. It replaces the fixed eight-letter, fixed-rate shift-register design in the lab 5 Morse path. A letter index is latched on a start request, and its dot/dash pattern is serialised on a single output at a configurable unit rate. The block reports busy/done status and supports abort, plus an optional auto-repeat mode. Output drives an LEDR bit directly; control comes from SW/KEY logic upstream.

## Interface
- TICK_CYCLES, 25_000_000, CLOCK_50 cycles per Morse unit (0.5 s at 50 MHz); legal range ≥1.
- PAT_W, 13, pattern register width; must be ≥13.
- CLOCK_50  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- letter_sel  input  5  letter index, 0=A … 25=Z; 26–31 invalid.
- start  input  1  synchronous request, sampled every posedge.
- abort  input  1  synchronous cancel.
- repeat  input  1  auto-repeat request; used only when MORSE_TX_REPEAT_EN is defined.
- morse_out  output  1  serial Morse symbol, 1 = tone/LED on.
- busy  output  1  high while in SEND or GAP.
- done  output  1  one-cycle pulse at the end of each letter.

## Operation
- Encoding, per standard Morse element order:
  - Dot = "1", dash = "111".
  - A single "0" separates consecutive elements.
  - The first element goes in the LSBs. Bits are emitted LSB first.
  - Length L = bit count.
  - Examples: E = 1 (L=1), T = 111 (L=3), S = 10101 (L=5), Z = 11101110101 (L=11).
  - Maximum length is 13 (J, Q, Y).
- ROM: internal combinational table of 26 {pattern[PAT_W-1:0], len[3:0]} entries.
- States:
  - IDLE → SEND on start=1 with letter_sel<26 and abort=0. Pattern and length are loaded and the unit counter is cleared.
  - SEND: morse_out = shift_reg[0]. Each time the unit counter reaches TICK_CYCLES-1, the register shifts right (zero fill), the counter wraps to 0, and the bit count decrements.
  - SEND → IDLE when the last bit's unit expires. done pulses in that same cycle.
  - GAP (repeat mode only): morse_out=0 for 3 units, then reloads from the current letter_sel and returns to SEND.
- start while busy: ignored, not queued.
- start with letter_sel ≥ 26: ignored. Block stays IDLE and done does not pulse.
- abort, when set in any state:
  - Next state is IDLE; morse_out=0 and busy=0 on the following cycle.
  - Counter is cleared and no done pulse is produced.
  - abort and start together in IDLE: abort wins.
- The unit counter is $clog2(TICK_CYCLES) bits wide (minimum 1). It runs only in SEND/GAP and restarts at 0 on every load, so the phase is aligned to acceptance of start.
- Asynchronous reset to IDLE at any time, including mid-letter. All outputs clear immediately.

## Timing
- Reset values: morse_out=0, busy=0, done=0, state=IDLE, counter=0, shift register=0.
- All outputs are registered.
- start accepted at edge k: from edge k onward, busy=1 and morse_out=bit0.
- Bit i occupies edges k+i·TICK_CYCLES through k+(i+1)·TICK_CYCLES-1.
- At edge k+L·TICK_CYCLES: morse_out=0 and busy=0 (non-repeat), with done=1 for exactly that one cycle.
- The earliest next start is accepted at edge k+L·TICK_CYCLES+1. A start held high across completion is accepted then, so a held start retransmits back-to-back with no gap.
- TICK_CYCLES=1: one bit per clock, with no stalls.

## Configuration
- MORSE_TX_REPEAT_EN defined:
  - At the end of a letter, done pulses.
  - If repeat=1 in that cycle: enter GAP with busy held 1, output 0 for 3·TICK_CYCLES cycles, then resample letter_sel and send again.
  - An invalid letter_sel at resample gives IDLE with busy=0.
  - repeat=0 at the end of a letter gives the normal return to IDLE.
- MORSE_TX_REPEAT_EN undefined: the GAP state is not synthesised, the repeat port is ignored, and behaviour is as in the non-repeat description.

## Test plan
- Send S: TICK_CYCLES=4, letter_sel=18, start pulse at edge 0 → morse_out 1,0,1,0,1 for 4 cycles each (edges 0–19), done=1 and busy=0 at edge 20.
- E and Z: letter_sel=4 → morse_out high for 4 cycles, done at +4. letter_sel=25 → 11101110101 serialised, done at +44.
- Invalid letter and busy start: letter_sel=30 with start → busy stays 0 and no done. A start pulse during an in-progress T → ignored, and done comes exactly once at +12.
- Abort and reset:
  - abort at edge 6 of an S transmission → morse_out=0 and busy=0 at edge 7, no done.
  - Reset low mid-letter → all outputs 0 asynchronously.
  - The next start after either works normally.
- Repeat mode (macro defined): TICK_CYCLES=2, letter_sel=19, repeat=1 → 111 (6 cycles), done, 000 gap (6 cycles), 111 again. Changing letter_sel to 4 during the gap sends E next.
- Rate extreme: TICK_CYCLES=1, letter_sel=24 (Y) → 13 consecutive bits 1110111010111 LSB-first, done at edge 13.
